dmi_core_req_queue: RTL and testbench
=====================================

Name: dmi_core_req_queue

Overview:
- Core-clock-domain successor to the JTAG/core DMI synchroniser's request path.
- Accepts already-synchronised DMI request pulses and buffers them in a parametrised FIFO.
- Issues them to the debug module over a valid/ready request and valid response handshake.
- Tracks per-transaction status and a sticky DMI op code (success/failed/busy) that is cleared by dmireset; supports multiple outstanding queued requests, unlike the single-shot predecessor.

Parameters:
- AW, 7, DMI address width.
- DW, 32, DMI data width.
- DEPTH, 4, request FIFO entries; power of two, >= 2.
- TIMEOUT, 1024, response-wait cycles before a transaction is failed; used only with the optional feature.

Ports:
- core_clk  in  1  core clock; the only clock.
- core_rst_n  in  1  synchronous active-low reset, sampled on posedge core_clk.
- dmireset  in  1  one-cycle pulse; clears sticky status and flushes the queue.
- req_valid  in  1  one-cycle request pulse (synchronised reg_en).
- req_wr  in  1  1 = write, 0 = read; qualified by req_valid.
- req_addr  in  AW  request address.
- req_wdata  in  DW  write data.
- dm_req_valid  out  1  request to debug module.
- dm_req_wr  out  1  write flag of the issued request.
- dm_req_addr  out  AW  issued address.
- dm_req_wdata  out  DW  issued write data.
- dm_req_ready  in  1  debug module accepts the request.
- dm_rsp_valid  in  1  one-cycle response pulse.
- dm_rsp_data  in  DW  read data.
- dm_rsp_err  in  1  response carries an error.
- rd_data  out  DW  last successful read data.
- rsp_done  out  1  one-cycle pulse when a transaction completes.
- opcod  out  2  DMI op status: 00 ok, 10 failed, 11 busy.
- busy  out  1  queue non-empty or transaction in flight.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: core_rst_n low at a posedge forces state IDLE, FIFO empty, and sticky = 00. All outputs go to 0, including rd_data, opcod, rsp_done, dm_req_* and fifo_count. Reset is honoured mid-transaction; any in-flight response arriving after reset is ignored.
- Push: req_valid with sticky == 00, FIFO not full and no dmireset writes {req_wr, req_addr, req_wdata}; fifo_count increments at the next edge.
  - req_valid while sticky != 00: request is dropped and sticky is unchanged.
  - req_valid while FIFO full: request is dropped and sticky <= 11 (overflow is reported as busy).
- FIFO: circular pointers with one extra wrap bit; full = count == DEPTH. A simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, ISSUE, WAIT_RSP.
  - IDLE -> ISSUE when the FIFO is non-empty.
  - ISSUE: dm_req_valid = 1 and dm_req_* driven from the FIFO head; these are held stable until dm_req_ready. On dm_req_ready: pop, -> WAIT_RSP.
  - WAIT_RSP: on dm_rsp_valid -> IDLE and rsp_done = 1 for one cycle.
    - If read and not error: rd_data <= dm_rsp_data.
    - If error: sticky <= 10 when sticky == 00.
- Latency: a req_valid sampled at edge N into an idle, empty block gives dm_req_valid high in the cycle after edge N+1. After a response there is a 1-cycle IDLE bubble before the next issue.
- Sticky priority: the first error wins; a later error never overwrites a nonzero sticky value.
- dmireset: has priority over a push in the same cycle; that push is dropped.
  - Flushes the FIFO (count <= 0) and clears sticky <= 00.
  - Does not abort ISSUE or WAIT_RSP; the in-flight transaction completes normally and can set sticky again.
- opcod register, updated every edge: sticky if sticky != 00; else 11 if busy; else 00. opcod lags the internal status by one cycle.
- busy (combinational) = (state != IDLE) or (fifo_count != 0).

Optional Feature:
- Macro: DMI_RSP_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT)+1 clears on entry to WAIT_RSP and increments each cycle.
  - When it reaches TIMEOUT-1 without dm_rsp_valid: -> IDLE, rsp_done pulses, sticky <= 10 (if 00), and rd_data is unchanged.
  - A dm_rsp_valid in the same cycle as the timeout wins, and the transaction is treated as a normal response.
- Not defined: no counter is built, WAIT_RSP waits indefinitely, and TIMEOUT is ignored.

Test Plan:
- Single read: push read addr 0x10 with dm_req_ready=1, then dm_rsp_valid with data 0xDEADBEEF, no err -> one dm_req_valid cycle, rd_data=0xDEADBEEF, rsp_done one pulse, opcod 11 while busy then 00.
- Burst fill: 5 back-to-back pushes with DEPTH=4 and dm_req_ready=0 -> fifo_count reaches 4, 5th dropped, opcod=11 sticky and stays 11 after the 4 transactions drain, until dmireset -> opcod 00.
- Error response: write returns dm_rsp_err=1 -> opcod=10; a later push is dropped (fifo_count stays 0); dmireset -> opcod 00 and new pushes accepted.
- dmireset with req_valid same cycle while 3 entries are queued and one is in WAIT_RSP -> fifo_count=0, the same-cycle push is dropped, and the in-flight response still yields rsp_done.
- Reset mid-WAIT_RSP: core_rst_n low for 1 cycle -> all outputs 0, state IDLE; a subsequent stale dm_rsp_valid produces no rsp_done.
- DMI_RSP_TIMEOUT_EN with TIMEOUT=8: no response after issue -> rsp_done and opcod=10 exactly 8 cycles after WAIT_RSP entry; dm_rsp_valid on that same cycle -> normal completion, opcod 00.

Source files
------------

// File: rtl/dmi_core_req_queue.sv
// dmi_core_req_queue
//   Core-clock DMI request queue. Already-synchronised DMI request pulses are
//   buffered in a DEPTH-entry FIFO and issued one at a time to the debug
//   module over a valid/ready request channel. The matching response comes
//   back as a one-cycle valid pulse. A sticky DMI op status
//   (00 ok, 10 failed, 11 busy/overflow) is kept until dmireset.
//
// Optional build macro: DMI_RSP_TIMEOUT_EN
//   When defined, a transaction whose response does not arrive within
//   TIMEOUT cycles of entering WAIT_RSP is completed as failed.
//   When undefined, WAIT_RSP waits indefinitely and TIMEOUT is ignored.
//
// Ports
//   core_clk, core_rst_n   : clock, synchronous active-low reset
//   dmireset               : pulse; flushes queue, clears sticky status
//   req_valid/wr/addr/wdata: incoming DMI request pulse
//   dm_req_*               : request to debug module (valid/ready)
//   dm_rsp_valid/data/err  : response pulse from debug module
//   rd_data                : last successful read data
//   rsp_done               : one-cycle pulse per completed transaction
//   opcod                  : registered DMI op status
//   busy                   : queue non-empty or transaction in flight
//   fifo_count             : current FIFO occupancy
module dmi_core_req_queue #(
  parameter int AW      = 7,
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       core_clk,
  input  logic                       core_rst_n,
  input  logic                       dmireset,
  input  logic                       req_valid,
  input  logic                       req_wr,
  input  logic [AW-1:0]              req_addr,
  input  logic [DW-1:0]              req_wdata,
  output logic                       dm_req_valid,
  output logic                       dm_req_wr,
  output logic [AW-1:0]              dm_req_addr,
  output logic [DW-1:0]              dm_req_wdata,
  input  logic                       dm_req_ready,
  input  logic                       dm_rsp_valid,
  input  logic [DW-1:0]              dm_rsp_data,
  input  logic                       dm_rsp_err,
  output logic [DW-1:0]              rd_data,
  output logic                       rsp_done,
  output logic [1:0]                 opcod,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + AW + DW;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_FAIL = 2'b10;
  localparam logic [1:0] ST_BUSY = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_e;

  // Control state (reset)
  state_e          state_q, state_d;
  logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            issue_live_q, issue_live_d;
  logic [1:0]      sticky_q, sticky_d;
  logic [1:0]      opcod_q, opcod_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rsp_done_q, rsp_done_d;

  // Datapath storage (no reset; only observed when qualified by control)
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   mem_d [DEPTH];
  logic            issue_wr_q, issue_wr_d;
  logic [AW-1:0]   issue_addr_q, issue_addr_d;
  logic [DW-1:0]   issue_wdata_q, issue_wdata_d;

  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            overflow;
  logic            pop;
  logic            rsp_take;
  logic            timeout;
  logic            err_evt;
  logic [EW-1:0]   head;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem_q[rd_ptr_q[PW-1:0]];

  // Requests are only accepted while status is clean; dmireset drops a
  // same-cycle request.
  assign push     = req_valid && !dmireset && (sticky_q == ST_OK) && !full;
  assign overflow = req_valid && !dmireset && (sticky_q == ST_OK) && full;

  // issue_live_q guards against popping an entry that a dmireset already
  // flushed while the request was being presented.
  assign pop      = (state_q == S_ISSUE) && dm_req_ready && issue_live_q && !dmireset;
  assign rsp_take = (state_q == S_WAIT_RSP) && dm_rsp_valid;

`ifdef DMI_RSP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // A response in the same cycle as the timeout takes precedence.
  assign timeout = (state_q == S_WAIT_RSP) && !dm_rsp_valid && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q == S_ISSUE) && dm_req_ready) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_WAIT_RSP) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout        = 1'b0;
`endif

  assign err_evt = (rsp_take && dm_rsp_err) || timeout;

  // ---- next-state: FIFO, FSM, status ----
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    issue_live_d  = issue_live_q;
    issue_wr_d    = issue_wr_q;
    issue_addr_d  = issue_addr_q;
    issue_wdata_d = issue_wdata_q;
    rd_data_d     = rd_data_q;
    rsp_done_d    = 1'b0;
    mem_d         = mem_q;

    if (push) begin
      mem_d[wr_ptr_q[PW-1:0]] = {req_wr, req_addr, req_wdata};
    end

    if (dmireset) begin
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!empty && !dmireset) begin
          state_d       = S_ISSUE;
          issue_live_d  = 1'b1;
          issue_wr_d    = head[EW-1];
          issue_addr_d  = head[DW +: AW];
          issue_wdata_d = head[DW-1:0];
        end
      end
      S_ISSUE: begin
        if (dm_req_ready) begin
          state_d      = S_WAIT_RSP;
          issue_live_d = 1'b0;
        end
      end
      S_WAIT_RSP: begin
        if (rsp_take) begin
          state_d    = S_IDLE;
          rsp_done_d = 1'b1;
          if (!issue_wr_q && !dm_rsp_err) begin
            rd_data_d = dm_rsp_data;
          end
        end else if (timeout) begin
          state_d    = S_IDLE;
          rsp_done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (dmireset) begin
      issue_live_d = 1'b0;
    end

    // First error wins: a nonzero sticky value is never overwritten. An
    // in-flight completion may re-set it right after a dmireset.
    sticky_d = dmireset ? ST_OK : sticky_q;
    if (overflow) begin
      sticky_d = ST_BUSY;
    end
    if (err_evt && (sticky_d == ST_OK)) begin
      sticky_d = ST_FAIL;
    end

    if (sticky_q != ST_OK) begin
      opcod_d = sticky_q;
    end else if (busy) begin
      opcod_d = ST_BUSY;
    end else begin
      opcod_d = ST_OK;
    end
  end

  // ---- register stage: control ----
  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      issue_live_q <= 1'b0;
      sticky_q     <= ST_OK;
      opcod_q      <= ST_OK;
      rd_data_q    <= '0;
      rsp_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      issue_live_q <= issue_live_d;
      sticky_q     <= sticky_d;
      opcod_q      <= opcod_d;
      rd_data_q    <= rd_data_d;
      rsp_done_q   <= rsp_done_d;
    end
  end

  // ---- register stage: data ----
  always_ff @(posedge core_clk) begin
    mem_q         <= mem_d;
    issue_wr_q    <= issue_wr_d;
    issue_addr_q  <= issue_addr_d;
    issue_wdata_q <= issue_wdata_d;
  end

  // Request fields are forced to zero outside ISSUE so that nothing stale
  // (or unreset) is visible on the debug-module interface.
  assign dm_req_valid = (state_q == S_ISSUE);
  assign dm_req_wr    = dm_req_valid && issue_wr_q;
  assign dm_req_addr  = dm_req_valid ? issue_addr_q  : '0;
  assign dm_req_wdata = dm_req_valid ? issue_wdata_q : '0;

  assign busy       = (state_q != S_IDLE) || !empty;
  assign fifo_count = count;
  assign rd_data    = rd_data_q;
  assign rsp_done   = rsp_done_q;
  assign opcod      = opcod_q;

endmodule

// File: tb/tb_dmi_core_req_queue.sv
// Self-checking bench for dmi_core_req_queue (AW=7, DW=32, DEPTH=4,
// TIMEOUT=8). Inputs change 1 time unit after a rising edge; outputs are
// compared at that same point, i.e. they show the state after that edge.
module tb_dmi_core_req_queue;

  logic        core_clk;
  logic        core_rst_n;
  logic        dmireset;
  logic        req_valid;
  logic        req_wr;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        dm_req_valid;
  logic        dm_req_wr;
  logic [6:0]  dm_req_addr;
  logic [31:0] dm_req_wdata;
  logic        dm_req_ready;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic        dm_rsp_err;
  logic [31:0] rd_data;
  logic        rsp_done;
  logic [1:0]  opcod;
  logic        busy;
  logic [2:0]  fifo_count;

  int n_cmp  = 0;
  int n_fail = 0;

  dmi_core_req_queue #(
    .AW(7), .DW(32), .DEPTH(4), .TIMEOUT(8)
  ) dut (
    .core_clk    (core_clk),
    .core_rst_n  (core_rst_n),
    .dmireset    (dmireset),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .dm_req_valid(dm_req_valid),
    .dm_req_wr   (dm_req_wr),
    .dm_req_addr (dm_req_addr),
    .dm_req_wdata(dm_req_wdata),
    .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid),
    .dm_rsp_data (dm_rsp_data),
    .dm_rsp_err  (dm_rsp_err),
    .rd_data     (rd_data),
    .rsp_done    (rsp_done),
    .opcod       (opcod),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  typedef struct {
    logic        rst_n, drst, rv, rwr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        rdy, sv;
    logic [31:0] sdata;
    logic        serr;
    logic        e_vld, e_wr;
    logic [6:0]  e_addr;
    logic [31:0] e_wd, e_rd;
    logic        e_done;
    logic [1:0]  e_op;
    logic        e_busy;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(
    input logic rst_n, drst, rv, rwr, input logic [6:0] addr, input logic [31:0] wdata,
    input logic rdy, sv, input logic [31:0] sdata, input logic serr,
    input logic e_vld, e_wr, input logic [6:0] e_addr, input logic [31:0] e_wd, e_rd,
    input logic e_done, input logic [1:0] e_op, input logic e_busy, input logic [2:0] e_cnt);
    vec_t r;
    r.rst_n = rst_n; r.drst = drst; r.rv = rv; r.rwr = rwr; r.addr = addr; r.wdata = wdata;
    r.rdy = rdy; r.sv = sv; r.sdata = sdata; r.serr = serr;
    r.e_vld = e_vld; r.e_wr = e_wr; r.e_addr = e_addr; r.e_wd = e_wd; r.e_rd = e_rd;
    r.e_done = e_done; r.e_op = e_op; r.e_busy = e_busy; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_rst_n   = 1'b1;
    dmireset     = 1'b0;
    req_valid    = 1'b0;
    req_wr       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    dm_req_ready = 1'b0;
    dm_rsp_valid = 1'b0;
    dm_rsp_data  = '0;
    dm_rsp_err   = 1'b0;
  endtask

  task automatic push_rd(input logic [6:0] a);
    idle_inputs();
    req_valid = 1'b1;
    req_addr  = a;
    step();
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] R1 = 32'h01020304;

  initial begin
    idle_inputs();
    core_rst_n = 1'b0;

    // rst drst rv rwr addr wdata rdy sv sdata serr | vld wr addr wd rd done op busy cnt
    // single read
    vq.push_back(v(0,0,0,0,7'h00,0,0,0,0,0, 0,0,7'h00,0,0,0,2'b00,0,0));
    vq.push_back(v(1,0,1,0,7'h10,0,1,0,0,0, 0,0,7'h00,0,0,0,2'b00,1,1));
    vq.push_back(v(1,0,0,0,7'h00,0,1,0,0,0, 1,0,7'h10,0,0,0,2'b11,1,1));
    vq.push_back(v(1,0,0,0,7'h00,0,1,0,0,0, 0,0,7'h00,0,0,0,2'b11,1,0));
    vq.push_back(v(1,0,0,0,7'h00,0,0,1,DB,0, 0,0,7'h00,0,DB,1,2'b11,0,0));
    vq.push_back(v(1,0,0,0,7'h00,0,0,0,0,0, 0,0,7'h00,0,DB,0,2'b00,0,0));
    // error response on a write
    vq.push_back(v(1,0,1,1,7'h22,32'h12345678,0,0,0,0, 0,0,7'h00,0,DB,0,2'b00,1,1));
    vq.push_back(v(1,0,0,0,7'h00,0,0,0,0,0, 1,1,7'h22,32'h12345678,DB,0,2'b11,1,1));
    vq.push_back(v(1,0,0,0,7'h00,0,0,0,0,0, 1,1,7'h22,32'h12345678,DB,0,2'b11,1,1));
    vq.push_back(v(1,0,0,0,7'h00,0,1,0,0,0, 0,0,7'h00,0,DB,0,2'b11,1,0));
    vq.push_back(v(1,0,0,0,7'h00,0,0,1,32'hAAAA5555,1, 0,0,7'h00,0,DB,1,2'b11,0,0));
    vq.push_back(v(1,0,1,0,7'h30,0,0,0,0,0, 0,0,7'h00,0,DB,0,2'b10,0,0));
    vq.push_back(v(1,1,0,0,7'h00,0,0,0,0,0, 0,0,7'h00,0,DB,0,2'b10,0,0));
    vq.push_back(v(1,0,0,0,7'h00,0,0,0,0,0, 0,0,7'h00,0,DB,0,2'b00,0,0));
    vq.push_back(v(1,0,1,0,7'h33,0,0,0,0,0, 0,0,7'h00,0,DB,0,2'b00,1,1));
    vq.push_back(v(1,0,0,0,7'h00,0,1,0,0,0, 1,0,7'h33,0,DB,0,2'b11,1,1));
    vq.push_back(v(1,0,0,0,7'h00,0,1,0,0,0, 0,0,7'h00,0,DB,0,2'b11,1,0));
    vq.push_back(v(1,0,0,0,7'h00,0,0,1,R1,0, 0,0,7'h00,0,R1,1,2'b11,0,0));
    vq.push_back(v(1,0,0,0,7'h00,0,0,0,0,0, 0,0,7'h00,0,R1,0,2'b00,0,0));
    // burst fill: 5 pushes, 5th overflows
    vq.push_back(v(1,0,1,0,7'h40,0,0,0,0,0, 0,0,7'h00,0,R1,0,2'b00,1,1));
    vq.push_back(v(1,0,1,0,7'h41,0,0,0,0,0, 1,0,7'h40,0,R1,0,2'b11,1,2));
    vq.push_back(v(1,0,1,0,7'h42,0,0,0,0,0, 1,0,7'h40,0,R1,0,2'b11,1,3));
    vq.push_back(v(1,0,1,0,7'h43,0,0,0,0,0, 1,0,7'h40,0,R1,0,2'b11,1,4));
    vq.push_back(v(1,0,1,0,7'h44,0,0,0,0,0, 1,0,7'h40,0,R1,0,2'b11,1,4));
    vq.push_back(v(1,0,0,0,7'h00,0,0,0,0,0, 1,0,7'h40,0,R1,0,2'b11,1,4));
    // drain
    vq.push_back(v(1,0,0,0,7'h00,0,1,0,0,0, 0,0,7'h00,0,R1,0,2'b11,1,3));
    vq.push_back(v(1,0,0,0,7'h00,0,0,1,32'h100,0, 0,0,7'h00,0,32'h100,1,2'b11,1,3));
    vq.push_back(v(1,0,0,0,7'h00,0,1,0,0,0, 1,0,7'h41,0,32'h100,0,2'b11,1,3));
    vq.push_back(v(1,0,0,0,7'h00,0,1,0,0,0, 0,0,7'h00,0,32'h100,0,2'b11,1,2));
    vq.push_back(v(1,0,0,0,7'h00,0,0,1,32'h101,0, 0,0,7'h00,0,32'h101,1,2'b11,1,2));
    vq.push_back(v(1,0,0,0,7'h00,0,1,0,0,0, 1,0,7'h42,0,32'h101,0,2'b11,1,2));
    vq.push_back(v(1,0,0,0,7'h00,0,1,0,0,0, 0,0,7'h00,0,32'h101,0,2'b11,1,1));
    vq.push_back(v(1,0,0,0,7'h00,0,0,1,32'h102,0, 0,0,7'h00,0,32'h102,1,2'b11,1,1));
    vq.push_back(v(1,0,0,0,7'h00,0,1,0,0,0, 1,0,7'h43,0,32'h102,0,2'b11,1,1));
    vq.push_back(v(1,0,0,0,7'h00,0,1,0,0,0, 0,0,7'h00,0,32'h102,0,2'b11,1,0));
    vq.push_back(v(1,0,0,0,7'h00,0,0,1,32'h103,0, 0,0,7'h00,0,32'h103,1,2'b11,0,0));
    vq.push_back(v(1,0,0,0,7'h00,0,0,0,0,0, 0,0,7'h00,0,32'h103,0,2'b11,0,0));
    vq.push_back(v(1,1,0,0,7'h00,0,0,0,0,0, 0,0,7'h00,0,32'h103,0,2'b11,0,0));
    vq.push_back(v(1,0,0,0,7'h00,0,0,0,0,0, 0,0,7'h00,0,32'h103,0,2'b00,0,0));

    for (int i = 0; i < vq.size(); i++) begin
      core_rst_n   = vq[i].rst_n;
      dmireset     = vq[i].drst;
      req_valid    = vq[i].rv;
      req_wr       = vq[i].rwr;
      req_addr     = vq[i].addr;
      req_wdata    = vq[i].wdata;
      dm_req_ready = vq[i].rdy;
      dm_rsp_valid = vq[i].sv;
      dm_rsp_data  = vq[i].sdata;
      dm_rsp_err   = vq[i].serr;
      step();
      chk($sformatf("v%0d dm_req_valid", i), 32'(dm_req_valid), 32'(vq[i].e_vld));
      chk($sformatf("v%0d dm_req_wr", i),    32'(dm_req_wr),    32'(vq[i].e_wr));
      chk($sformatf("v%0d dm_req_addr", i),  32'(dm_req_addr),  32'(vq[i].e_addr));
      chk($sformatf("v%0d dm_req_wdata", i), dm_req_wdata,      vq[i].e_wd);
      chk($sformatf("v%0d rd_data", i),      rd_data,           vq[i].e_rd);
      chk($sformatf("v%0d rsp_done", i),     32'(rsp_done),     32'(vq[i].e_done));
      chk($sformatf("v%0d opcod", i),        32'(opcod),        32'(vq[i].e_op));
      chk($sformatf("v%0d busy", i),         32'(busy),         32'(vq[i].e_busy));
      chk($sformatf("v%0d fifo_count", i),   32'(fifo_count),   32'(vq[i].e_cnt));
    end

    // dmireset + same-cycle push with 3 queued and one in WAIT_RSP
    push_rd(7'h50);
    push_rd(7'h51);
    push_rd(7'h52);
    push_rd(7'h53);
    chk("flush pre count", 32'(fifo_count), 32'd4);
    chk("flush pre addr", 32'(dm_req_addr), 32'h50);
    idle_inputs();
    dm_req_ready = 1'b1;
    step();
    chk("flush wait count", 32'(fifo_count), 32'd3);
    chk("flush wait busy", 32'(busy), 32'd1);
    idle_inputs();
    dmireset  = 1'b1;
    req_valid = 1'b1;
    req_addr  = 7'h60;
    step();
    chk("flush count", 32'(fifo_count), 32'd0);
    chk("flush busy inflight", 32'(busy), 32'd1);
    idle_inputs();
    dm_rsp_valid = 1'b1;
    dm_rsp_data  = 32'h77;
    step();
    chk("flush rsp_done", 32'(rsp_done), 32'd1);
    chk("flush rd_data", rd_data, 32'h77);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("flush idle%0d dm_req_valid", k), 32'(dm_req_valid), 32'd0);
      chk($sformatf("flush idle%0d count", k), 32'(fifo_count), 32'd0);
    end
    chk("flush opcod", 32'(opcod), 32'd0);

    // reset in the middle of WAIT_RSP
    push_rd(7'h70);
    idle_inputs();
    step();
    chk("rst issue valid", 32'(dm_req_valid), 32'd1);
    dm_req_ready = 1'b1;
    step();
    chk("rst pre busy", 32'(busy), 32'd1);
    chk("rst pre opcod", 32'(opcod), 32'd3);
    idle_inputs();
    core_rst_n = 1'b0;
    step();
    chk("rst dm_req_valid", 32'(dm_req_valid), 32'd0);
    chk("rst dm_req_addr", 32'(dm_req_addr), 32'd0);
    chk("rst rd_data", rd_data, 32'd0);
    chk("rst rsp_done", 32'(rsp_done), 32'd0);
    chk("rst opcod", 32'(opcod), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst fifo_count", 32'(fifo_count), 32'd0);
    idle_inputs();
    dm_rsp_valid = 1'b1;
    dm_rsp_data  = 32'h99;
    step();
    chk("stale rsp_done", 32'(rsp_done), 32'd0);
    chk("stale rd_data", rd_data, 32'd0);
    idle_inputs();
    step();
    chk("stale rsp_done2", 32'(rsp_done), 32'd0);
    chk("stale busy", 32'(busy), 32'd0);

`ifdef DMI_RSP_TIMEOUT_EN
    // no response: timeout completes 8 cycles after WAIT_RSP entry
    push_rd(7'h05);
    idle_inputs();
    step();
    dm_req_ready = 1'b1;
    step();
    idle_inputs();
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("tmo c%0d rsp_done", k), 32'(rsp_done), 32'd0);
    end
    step();
    chk("tmo rsp_done", 32'(rsp_done), 32'd1);
    chk("tmo rd_data", rd_data, 32'd0);
    chk("tmo busy", 32'(busy), 32'd0);
    step();
    chk("tmo opcod", 32'(opcod), 32'd2);
    dmireset = 1'b1;
    step();
    idle_inputs();
    step();
    chk("tmo clr opcod", 32'(opcod), 32'd0);

    // response on the timeout cycle wins
    push_rd(7'h06);
    idle_inputs();
    step();
    dm_req_ready = 1'b1;
    step();
    idle_inputs();
    for (int k = 1; k <= 7; k++) begin
      step();
    end
    dm_rsp_valid = 1'b1;
    dm_rsp_data  = 32'h5A;
    step();
    chk("tmo race rsp_done", 32'(rsp_done), 32'd1);
    chk("tmo race rd_data", rd_data, 32'h5A);
    idle_inputs();
    step();
    chk("tmo race opcod", 32'(opcod), 32'd0);
    step();
    chk("tmo race opcod2", 32'(opcod), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
